// File: rtl/read_req_pkg.sv
// -----------------------------------------------------------------------------
// read_req_pkg
// Shared definitions for the AXI read-request generator:
//   - state_t            : controller states (IDLE, CALC, ADDR, DONE)
//   - AXI_BURST_INCR     : AXI incrementing burst encoding
//   - BOUNDARY_4KB       : AXI page size that a burst must never cross
//   - beats_to_boundary(): beats left before the next 4KB page boundary
// No ports (package).
// -----------------------------------------------------------------------------
package read_req_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        ADDR = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam int         BOUNDARY_4KB   = 4096;

    // addr_low is the byte offset inside the current 4KB page and is already
    // beat-aligned, so the shift is exact. Result range: 1 .. 4096>>beat_shift.
    function automatic logic [12:0] beats_to_boundary(input logic [11:0] addr_low,
                                                      input int          beat_shift);
        logic [12:0] bytes_left;
        bytes_left = 13'(BOUNDARY_4KB) - {1'b0, addr_low};
        return bytes_left >> beat_shift;
    endfunction

endpackage

// File: rtl/read_burst_calc.sv
// -----------------------------------------------------------------------------
// read_burst_calc
// Combinational burst sizing: len = min(remaining, MAX_BURST_LEN, beats to the
// next 4KB boundary).
// Ports:
//   addr      in  12      byte offset of the next burst within its 4KB page
//   remaining in  SIZE_W  beats still to be requested (non-zero when used)
//   len       out 9       beats for the next burst (1 .. 256)
// -----------------------------------------------------------------------------
module read_burst_calc
    import read_req_pkg::*;
#(
    parameter int SIZE_W        = 20,
    parameter int MAX_BURST_LEN = 16,
    parameter int BEAT_SHIFT    = 3
) (
    input  logic [11:0]       addr,
    input  logic [SIZE_W-1:0] remaining,
    output logic [8:0]        len
);

    // Common compare width wide enough for every candidate.
    localparam int CW = (SIZE_W > 13) ? SIZE_W : 13;

    logic [CW-1:0] rem_w;
    logic [CW-1:0] bnd_w;
    logic [CW-1:0] max_w;
    logic [CW-1:0] min_w;

    always_comb begin
        rem_w = CW'(remaining);
        bnd_w = CW'(beats_to_boundary(addr, BEAT_SHIFT));
        max_w = CW'(MAX_BURST_LEN);
        min_w = rem_w;
        if (bnd_w < min_w) min_w = bnd_w;
        if (max_w < min_w) min_w = max_w;
        // min_w never exceeds MAX_BURST_LEN (<= 256), so 9 bits suffice.
        len = 9'(min_w);
    end

endmodule

// File: rtl/read_req_gen.sv
// -----------------------------------------------------------------------------
// read_req_gen
// Splits one read command (start address + beat count) into AXI INCR read
// bursts that never exceed MAX_BURST_LEN beats nor cross a 4KB boundary, and
// pushes one entry per issued burst into a downstream read-info FIFO.
//
// Optional feature: define READ_REQ_GEN_STATS_EN to add the saturating
// statistics counters stat_bursts and stat_stall_cycles.
//
// Ports:
//   clk, reset            clock, synchronous active-low reset (0 = reset)
//   rd_cmd_*              command handshake (ready only in IDLE): start byte
//                         address, total beats, PU id, data type
//   m_axi_ar*             AXI read-address channel (arsize/arburst constant)
//   rd_req, rd_req_*      one-cycle FIFO push: burst beats-1, PU id, data type
//   read_info_full        FIFO full; blocks issuing the next burst
//   rd_done               one-cycle pulse when a command has completed
//   busy                  high whenever the controller is not IDLE
//   stat_bursts           (stats build) AR handshakes since reset
//   stat_stall_cycles     (stats build) ADDR cycles without arready plus
//                         CALC cycles with read_info_full
// -----------------------------------------------------------------------------
module read_req_gen
    import read_req_pkg::*;
#(
    parameter int AXI_ADDR_W    = 32,
    parameter int AXI_DATA_W    = 64,
    parameter int MAX_BURST_LEN = 16,
    parameter int TX_SIZE_W     = 20,
    parameter int RD_SIZE_W     = 20,
    parameter int PU_ID_W       = 2,
    parameter int D_TYPE_W      = 2
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  rd_cmd_valid,
    output logic                  rd_cmd_ready,
    input  logic [AXI_ADDR_W-1:0] rd_cmd_addr,
    input  logic [TX_SIZE_W-1:0]  rd_cmd_beats,
    input  logic [PU_ID_W-1:0]    rd_cmd_pu_id,
    input  logic [D_TYPE_W-1:0]   rd_cmd_d_type,

    output logic [AXI_ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    output logic                  rd_req,
    output logic [RD_SIZE_W-1:0]  rd_req_size,
    output logic [PU_ID_W-1:0]    rd_req_pu_id,
    output logic [D_TYPE_W-1:0]   rd_req_d_type,
    input  logic                  read_info_full,

    output logic                  rd_done,
`ifdef READ_REQ_GEN_STATS_EN
    output logic [31:0]           stat_bursts,
    output logic [31:0]           stat_stall_cycles,
`endif
    output logic                  busy
);

    localparam int BEAT_BYTES = AXI_DATA_W / 8;
    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam logic [AXI_ADDR_W-1:0] ADDR_LOW_MASK = AXI_ADDR_W'(BEAT_BYTES - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [AXI_ADDR_W-1:0]   addr_q;
    logic [TX_SIZE_W-1:0]    remaining_q;
    logic [PU_ID_W-1:0]      pu_id_q;
    logic [D_TYPE_W-1:0]     d_type_q;
    logic [7:0]              arlen_q;
    logic [8:0]              calc_len;
    logic [8:0]              burst_len;
    logic                    ar_hs;

    read_burst_calc #(
        .SIZE_W        (TX_SIZE_W),
        .MAX_BURST_LEN (MAX_BURST_LEN),
        .BEAT_SHIFT    (BEAT_SHIFT)
    ) u_burst_calc (
        .addr      (addr_q[11:0]),
        .remaining (remaining_q),
        .len       (calc_len)
    );

    // Beats of the burst currently presented on AR (arlen is beats-1).
    assign burst_len = {1'b0, arlen_q} + 9'd1;
    assign ar_hs     = (state == ADDR) && m_axi_arready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nxt; no latch.
        state_nxt = state;
        unique case (state)
            IDLE: if (rd_cmd_valid)
                      state_nxt = (rd_cmd_beats == '0) ? DONE : CALC;
            // rd_req still high means the previous push has not yet been
            // reflected in read_info_full; wait one cycle for a valid flag.
            CALC: if (!read_info_full && !rd_req)
                      state_nxt = ADDR;
            ADDR: if (m_axi_arready)
                      state_nxt = (remaining_q == TX_SIZE_W'(burst_len)) ? DONE : CALC;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q        <= '0;
            remaining_q   <= '0;
            pu_id_q       <= '0;
            d_type_q      <= '0;
            arlen_q       <= '0;
            rd_req        <= 1'b0;
            rd_req_size   <= '0;
            rd_req_pu_id  <= '0;
            rd_req_d_type <= '0;
        end else begin
            rd_req <= 1'b0;
            unique case (state)
                IDLE: if (rd_cmd_valid) begin
                    addr_q      <= rd_cmd_addr & ~ADDR_LOW_MASK;
                    remaining_q <= rd_cmd_beats;
                    pu_id_q     <= rd_cmd_pu_id;
                    d_type_q    <= rd_cmd_d_type;
                end
                CALC: arlen_q <= 8'(calc_len - 9'd1);
                ADDR: if (m_axi_arready) begin
                    // Wraps modulo 2^AXI_ADDR_W by construction.
                    addr_q        <= addr_q + (AXI_ADDR_W'(burst_len) << BEAT_SHIFT);
                    remaining_q   <= remaining_q - TX_SIZE_W'(burst_len);
                    rd_req        <= 1'b1;
                    rd_req_size   <= RD_SIZE_W'(arlen_q);
                    rd_req_pu_id  <= pu_id_q;
                    rd_req_d_type <= d_type_q;
                end
                default: ;
            endcase
        end
    end

    // AR payload comes straight from registers that only move outside ADDR,
    // so it is stable while arvalid waits for arready.
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = 3'(BEAT_SHIFT);
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arvalid = (state == ADDR);

    assign rd_cmd_ready  = (state == IDLE);
    assign rd_done       = (state == DONE);
    assign busy          = (state != IDLE);

`ifdef READ_REQ_GEN_STATS_EN
    logic stall;
    assign stall = ((state == ADDR) && !m_axi_arready) ||
                   ((state == CALC) && read_info_full);

    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_bursts       <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (ar_hs && (stat_bursts != '1))
                stat_bursts <= stat_bursts + 32'd1;
            if (stall && (stat_stall_cycles != '1))
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_read_req_gen.sv
// -----------------------------------------------------------------------------
// tb_read_req_gen
// Directed bench for read_req_gen (AXI_DATA_W=64, MAX_BURST_LEN=16). Expected
// AR bursts and FIFO pushes are queued when a command is driven and popped by
// a negedge monitor when the DUT produces them.
// -----------------------------------------------------------------------------
module tb_read_req_gen;

    localparam int AW = 32;
    localparam int TW = 20;
    localparam int RW = 20;

    logic          clk;
    logic          reset;
    logic          rd_cmd_valid;
    logic          rd_cmd_ready;
    logic [AW-1:0] rd_cmd_addr;
    logic [TW-1:0] rd_cmd_beats;
    logic [1:0]    rd_cmd_pu_id;
    logic [1:0]    rd_cmd_d_type;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic [2:0]    m_axi_arsize;
    logic [1:0]    m_axi_arburst;
    logic          m_axi_arvalid;
    logic          m_axi_arready;
    logic          rd_req;
    logic [RW-1:0] rd_req_size;
    logic [1:0]    rd_req_pu_id;
    logic [1:0]    rd_req_d_type;
    logic          read_info_full;
    logic          rd_done;
    logic          busy;
`ifdef READ_REQ_GEN_STATS_EN
    logic [31:0]   stat_bursts;
    logic [31:0]   stat_stall_cycles;
`endif

    read_req_gen dut (
        .clk            (clk),
        .reset          (reset),
        .rd_cmd_valid   (rd_cmd_valid),
        .rd_cmd_ready   (rd_cmd_ready),
        .rd_cmd_addr    (rd_cmd_addr),
        .rd_cmd_beats   (rd_cmd_beats),
        .rd_cmd_pu_id   (rd_cmd_pu_id),
        .rd_cmd_d_type  (rd_cmd_d_type),
        .m_axi_araddr   (m_axi_araddr),
        .m_axi_arlen    (m_axi_arlen),
        .m_axi_arsize   (m_axi_arsize),
        .m_axi_arburst  (m_axi_arburst),
        .m_axi_arvalid  (m_axi_arvalid),
        .m_axi_arready  (m_axi_arready),
        .rd_req         (rd_req),
        .rd_req_size    (rd_req_size),
        .rd_req_pu_id   (rd_req_pu_id),
        .rd_req_d_type  (rd_req_d_type),
        .read_info_full (read_info_full),
        .rd_done        (rd_done),
`ifdef READ_REQ_GEN_STATS_EN
        .stat_bursts       (stat_bursts),
        .stat_stall_cycles (stat_stall_cycles),
`endif
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: {araddr, arlen} and {size, pu_id, d_type}.
    logic [39:0] ar_q[$];
    logic [23:0] rq_q[$];
    int ar_count   = 0;
    int rq_count   = 0;
    int done_count = 0;
    int av_count   = 0;

    task automatic push_burst(input logic [31:0] addr, input logic [7:0] arlen,
                              input logic [1:0] pu, input logic [1:0] dt);
        ar_q.push_back({addr, arlen});
        rq_q.push_back({12'd0, arlen, pu, dt});
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    logic        hs_now, hs_prev, done_prev, stall_prev;
    logic [31:0] prev_addr;
    logic [7:0]  prev_len;
    logic [39:0] ar_e;
    logic [23:0] rq_e;

    always @(negedge clk) begin
        if (reset) begin
            hs_now = m_axi_arvalid && m_axi_arready;
            if (m_axi_arvalid) av_count++;
            if (stall_prev && m_axi_arvalid) begin
                check("araddr_stable", m_axi_araddr, prev_addr);
                check("arlen_stable", m_axi_arlen, prev_len);
            end
            if (hs_now) begin
                if (ar_q.size() == 0) check("ar_unexpected", hs_now, 1'b0);
                else begin
                    ar_e = ar_q.pop_front();
                    check("araddr", m_axi_araddr, ar_e[39:8]);
                    check("arlen", m_axi_arlen, ar_e[7:0]);
                end
                check("arsize", m_axi_arsize, 3'd3);
                check("arburst", m_axi_arburst, 2'b01);
                ar_count++;
            end
            if (rd_req || hs_prev) check("rd_req_timing", rd_req, hs_prev);
            if (rd_req) begin
                check("full_at_push", read_info_full, 1'b0);
                if (rq_q.size() == 0) check("rq_unexpected", rd_req, 1'b0);
                else begin
                    rq_e = rq_q.pop_front();
                    check("rd_req_size", rd_req_size, rq_e[23:4]);
                    check("rd_req_pu_id", rd_req_pu_id, rq_e[3:2]);
                    check("rd_req_d_type", rd_req_d_type, rq_e[1:0]);
                end
                rq_count++;
            end
            if (rd_done) begin
                check("rd_done_single", done_prev, 1'b0);
                done_count++;
            end
            if (busy) check("ready_when_busy", rd_cmd_ready, 1'b0);
            hs_prev    = hs_now;
            done_prev  = rd_done;
            stall_prev = m_axi_arvalid && !m_axi_arready;
            prev_addr  = m_axi_araddr;
            prev_len   = m_axi_arlen;
        end else begin
            hs_prev    = 1'b0;
            done_prev  = 1'b0;
            stall_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one command; returns just after the accepting edge.
    task automatic send(input logic [31:0] addr, input logic [TW-1:0] beats,
                        input logic [1:0] pu, input logic [1:0] dt);
        for (int i = 0; i < 100 && !rd_cmd_ready; i++) tick();
        check("cmd_ready_wait", rd_cmd_ready, 1'b1);
        rd_cmd_valid  = 1'b1;
        rd_cmd_addr   = addr;
        rd_cmd_beats  = beats;
        rd_cmd_pu_id  = pu;
        rd_cmd_d_type = dt;
        tick();
        rd_cmd_valid  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int start;
        start = done_count;
        for (int i = 0; i < 300 && done_count == start; i++) tick();
        tick();
        check(tag, done_count, start + 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    int lat;
    int base_rq, base_av, base_done, base_ar;
`ifdef READ_REQ_GEN_STATS_EN
    logic [31:0] sb0, ss0;
`endif

    initial begin
        reset          = 1'b0;
        rd_cmd_valid   = 1'b0;
        rd_cmd_addr    = '0;
        rd_cmd_beats   = '0;
        rd_cmd_pu_id   = '0;
        rd_cmd_d_type  = '0;
        m_axi_arready  = 1'b1;
        read_info_full = 1'b0;

        // Reset state.
        repeat (3) tick();
        check("rst_arvalid", m_axi_arvalid, 1'b0);
        check("rst_rd_req", rd_req, 1'b0);
        check("rst_rd_done", rd_done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_araddr", m_axi_araddr, 32'd0);
        check("rst_arlen", m_axi_arlen, 8'd0);
        check("rst_size", rd_req_size, 20'd0);
        check("rst_pu_id", rd_req_pu_id, 2'd0);
        check("rst_d_type", rd_req_d_type, 2'd0);
        check("rst_arsize", m_axi_arsize, 3'd3);
        check("rst_arburst", m_axi_arburst, 2'b01);
        reset = 1'b1;
        tick();
        check("ready_after_reset", rd_cmd_ready, 1'b1);

        // 40 beats from 0x1000: 16 + 16 + 8.
        push_burst(32'h1000, 8'd15, 2'b10, 2'b01);
        push_burst(32'h1080, 8'd15, 2'b10, 2'b01);
        push_burst(32'h1100, 8'd7,  2'b10, 2'b01);
        send(32'h1000, 20'd40, 2'b10, 2'b01);
        lat = 1;
        for (int i = 0; i < 20 && !m_axi_arvalid; i++) begin tick(); lat++; end
        check("accept_to_arvalid", lat, 2);
        wait_done("done_40beats");
        check("ar_q_empty_40", ar_q.size(), 0);
        check("rq_q_empty_40", rq_q.size(), 0);
        check("ready_after_done", rd_cmd_ready, 1'b1);

        // Unaligned start address: low three bits ignored.
        push_burst(32'h2000, 8'd1, 2'b01, 2'b10);
        send(32'h2007, 20'd2, 2'b01, 2'b10);
        wait_done("done_unaligned");

        // Zero beats: accepted, completion only.
        base_av   = av_count;
        base_rq   = rq_count;
        base_done = done_count;
        send(32'h4000, 20'd0, 2'b11, 2'b11);
        check("zero_rd_done", rd_done, 1'b1);
        check("zero_arvalid", m_axi_arvalid, 1'b0);
        tick();
        check("zero_rd_done_low", rd_done, 1'b0);
        check("zero_ready", rd_cmd_ready, 1'b1);
        check("zero_no_arvalid", av_count, base_av);
        check("zero_no_rd_req", rq_count, base_rq);
        check("zero_done_count", done_count, base_done + 1);

        // FIFO full for 4 CALC cycles, then arready low for 5 ADDR cycles.
`ifdef READ_REQ_GEN_STATS_EN
        sb0 = stat_bursts;
        ss0 = stat_stall_cycles;
`endif
        base_rq        = rq_count;
        read_info_full = 1'b1;
        m_axi_arready  = 1'b0;
        push_burst(32'h3000, 8'd7, 2'b00, 2'b10);
        send(32'h3000, 20'd8, 2'b00, 2'b10);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("full_arvalid_low", m_axi_arvalid, 1'b0);
        end
        read_info_full = 1'b0;
        tick();
        check("arvalid_after_full", m_axi_arvalid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("arvalid_held", m_axi_arvalid, 1'b1);
        end
        m_axi_arready = 1'b1;
        wait_done("done_stall");
        check("stall_single_push", rq_count, base_rq + 1);
`ifdef READ_REQ_GEN_STATS_EN
        check("stat_bursts", stat_bursts - sb0, 32'd1);
        check("stat_stall_cycles", stat_stall_cycles - ss0, 32'd9);
`endif

        // Reset during the second burst of a 40-beat command.
        base_done = done_count;
        base_ar   = ar_count;
        push_burst(32'h1000, 8'd15, 2'b01, 2'b01);
        send(32'h1000, 20'd40, 2'b01, 2'b01);
        for (int i = 0; i < 50 && ar_count == base_ar; i++) tick();
        check("first_burst_seen", ar_count, base_ar + 1);
        m_axi_arready = 1'b0;
        for (int i = 0; i < 20 && !m_axi_arvalid; i++) tick();
        check("second_burst_arvalid", m_axi_arvalid, 1'b1);
        reset = 1'b0;
        tick();
        check("mid_rst_arvalid", m_axi_arvalid, 1'b0);
        check("mid_rst_rd_req", rd_req, 1'b0);
        check("mid_rst_rd_done", rd_done, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_araddr", m_axi_araddr, 32'd0);
        check("mid_rst_arlen", m_axi_arlen, 8'd0);
        check("mid_rst_size", rd_req_size, 20'd0);
        reset         = 1'b1;
        m_axi_arready = 1'b1;
        tick();
        check("mid_rst_ready", rd_cmd_ready, 1'b1);
        check("mid_rst_no_done", done_count, base_done);
        check("mid_rst_queue", ar_q.size(), 0);

        // 4KB boundary split after reset.
        push_burst(32'h0FC0, 8'd7, 2'b01, 2'b11);
        push_burst(32'h1000, 8'd7, 2'b01, 2'b11);
        send(32'h0FC0, 20'd16, 2'b01, 2'b11);
        wait_done("done_4kb");
        check("ar_q_empty_4kb", ar_q.size(), 0);
        check("rq_q_empty_4kb", rq_q.size(), 0);

        // Address wrap at the top of the address space.
        push_burst(32'hFFFF_FF80, 8'd15, 2'b10, 2'b00);
        push_burst(32'h0000_0000, 8'd3,  2'b10, 2'b00);
        send(32'hFFFF_FF80, 20'd20, 2'b10, 2'b00);
        wait_done("done_wrap");
        check("ar_q_empty_wrap", ar_q.size(), 0);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
